mem_arbiter: RTL and testbench

Single-port byte memory arbiter between the CPU's instruction-fetch path and its data path. It serialises a 6-byte instruction-window fetch, a 2-byte data read or a 2-byte data write into byte accesses on one synchronous 8-bit SRAM port. It assembles little-endian results and returns them to the requester with a one-cycle acknowledge. It sits between the CPU core and main memory, replacing the ideal multi-port memory model used in simulation.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arb_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the byte-serialising memory arbiter.
// Included by the grant picker and the arbiter FSM.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam int FETCH_BYTES = 6;
    localparam int DATA_BYTES  = 2;

    localparam logic [3:0] STARVE_MAX = 4'd15;

    // Number of bytes a read transaction transfers; also the final READ count value.
    function automatic logic [2:0] last_cnt(input owner_t own);
        return (own == OWN_FETCH) ? 3'(FETCH_BYTES) : 3'(DATA_BYTES);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: data normally wins a tie, fetch wins once
// it has been passed over STARVE_LIMIT times in a row.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
)
(
    input  logic       f_req,
    input  logic       d_req,
    input  logic [3:0] starve,
    output logic       grant,
    output owner_t     owner
);

    always_comb begin
        grant = f_req | d_req;
        owner = OWN_DATA;
        if (f_req && (!d_req || int'(starve) >= STARVE_LIMIT)) begin
            owner = OWN_FETCH;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch (6 bytes) and data read/write (2 bytes) onto
// a single synchronous 8-bit SRAM port, assembling little-endian results.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 20
)
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [47:0]       f_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [15:0]       d_wdata,
    output logic              d_ack,
    output logic [15:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_out,
    output logic              mem_wr,
    input  logic [7:0]        mem_in
);

    state_t            state;
    owner_t            own;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] base;
    logic [7:0]        wdata_hi;
    logic [3:0]        starve;

    logic              grant;
    owner_t            grant_owner;
    logic [2:0]        last;
    logic [2:0]        cnt_inc;
    logic [ADDR_W-1:0] next_addr;

    mem_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .f_req  (f_req),
        .d_req  (d_req),
        .starve (starve),
        .grant  (grant),
        .owner  (grant_owner)
    );

    // The SRAM returns data a cycle late, so the final READ cycle re-presents
    // the last byte address while the last byte is being captured.
    always_comb begin
        last      = last_cnt(own);
        cnt_inc   = cnt + 3'd1;
        next_addr = base + ADDR_W'((cnt_inc < last) ? cnt_inc : (last - 3'd1));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            own      <= OWN_FETCH;
            cnt      <= 3'd0;
            base     <= '0;
            wdata_hi <= 8'd0;
            starve   <= 4'd0;
            f_ack    <= 1'b0;
            d_ack    <= 1'b0;
            f_data   <= 48'd0;
            d_rdata  <= 16'd0;
            mem_addr <= '0;
            mem_out  <= 8'd0;
            mem_wr   <= 1'b0;
        end else begin
            f_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        own <= grant_owner;
                        cnt <= 3'd0;
                        if (grant_owner == OWN_FETCH) begin
                            base     <= f_addr;
                            mem_addr <= f_addr;
                            starve   <= 4'd0;
                            state    <= ST_READ;
                        end else begin
                            base     <= d_addr;
                            mem_addr <= d_addr;
                            wdata_hi <= d_wdata[15:8];
                            if (f_req && starve != STARVE_MAX) begin
                                starve <= starve + 4'd1;
                            end
                            if (d_we) begin
                                mem_wr  <= 1'b1;
                                mem_out <= d_wdata[7:0];
                                state   <= ST_WRITE;
                            end else begin
                                state <= ST_READ;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (cnt != 3'd0) begin
                        if (own == OWN_FETCH) begin
                            for (int i = 0; i < FETCH_BYTES; i++) begin
                                if (cnt == 3'(i + 1)) begin
                                    f_data[8*i +: 8] <= mem_in;
                                end
                            end
                        end else if (cnt == 3'd1) begin
                            d_rdata[7:0] <= mem_in;
                        end else begin
                            d_rdata[15:8] <= mem_in;
                        end
                    end
                    if (cnt == last) begin
                        state <= ST_ACK;
                        f_ack <= (own == OWN_FETCH);
                        d_ack <= (own == OWN_DATA);
                    end else begin
                        cnt      <= cnt_inc;
                        mem_addr <= next_addr;
                    end
                end
                ST_WRITE: begin
                    if (cnt == 3'(DATA_BYTES - 1)) begin
                        mem_wr <= 1'b0;
                        d_ack  <= 1'b1;
                        state  <= ST_ACK;
                    end else begin
                        cnt      <= cnt_inc;
                        mem_addr <= base + ADDR_W'(cnt_inc);
                        mem_out  <= wdata_hi;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model of arbitration, latency and memory.
module tb_mem_arbiter;

    localparam int AW    = 20;
    localparam int LIMIT = 4;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          f_req   = 1'b0;
    logic [AW-1:0] f_addr  = '0;
    logic          f_ack;
    logic [47:0]   f_data;
    logic          d_req   = 1'b0;
    logic          d_we    = 1'b0;
    logic [AW-1:0] d_addr  = '0;
    logic [15:0]   d_wdata = 16'd0;
    logic          d_ack;
    logic [15:0]   d_rdata;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_out;
    logic          mem_wr;
    logic [7:0]    mem_in;

    mem_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .ADDR_W(AW)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_ack    (f_ack),
        .f_data   (f_data),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_addr (mem_addr),
        .mem_out  (mem_out),
        .mem_wr   (mem_wr),
        .mem_in   (mem_in)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        if (a >= 20'h00100 && a <= 20'h00105) return 8'(a - 20'h000FF);
        if (a == 20'hFFFFF) return 8'h34;
        if (a == 20'h00000) return 8'h12;
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    // Synchronous SRAM: one-cycle read latency, write at the end of the cycle.
    logic [7:0] sram [0:(1<<AW)-1];
    bit         sram_ready = 1'b0;
    always @(posedge clock) begin
        if (!sram_ready) begin
            for (int i = 0; i < (1 << AW); i++) sram[i] <= init_byte(AW'(i));
            sram_ready <= 1'b1;
        end else if (mem_wr) begin
            sram[mem_addr] <= mem_out;
        end
        mem_in <= sram[mem_addr];
    end

    // Reference model state
    logic [7:0]  ref_mem [0:(1<<AW)-1];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc, free_at, starve_m, f_due, d_due, wr_lo, wr_hi;
    bit          f_granted, d_granted, d_is_read;
    logic [47:0] f_exp;
    logic [15:0] d_exp;
    string       dut_seq;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        f_req = 1'b0; d_req = 1'b0;
        f_granted = 1'b0; d_granted = 1'b0;
        f_due = -1; d_due = -1;
        wr_lo = 1; wr_hi = 0;
        starve_m = 0;
        free_at = cyc;
    endtask

    task automatic issue_fetch(input logic [AW-1:0] a);
        f_addr = a; f_req = 1'b1; f_granted = 1'b0;
    endtask

    task automatic issue_data(input bit we, input logic [AW-1:0] a, input logic [15:0] w);
        d_we = we; d_addr = a; d_wdata = w; d_req = 1'b1; d_granted = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 127));
        return 20'hFFFF8 + AW'($urandom_range(0, 7));
    endfunction

    // Decide what the arbiter grants in the current cycle, if it is idle.
    task automatic arbitrate();
        bit            fw, dw;
        logic [AW-1:0] a;
        fw = f_req && !f_granted;
        dw = d_req && !d_granted;
        if (cyc < free_at || !(fw || dw)) return;
        if (fw && (!dw || starve_m >= LIMIT)) begin
            starve_m  = 0;
            f_granted = 1'b1;
            f_due     = cyc + 8;
            free_at   = cyc + 9;
            for (int i = 0; i < 6; i++) begin
                a = f_addr + AW'(i);
                f_exp[8*i +: 8] = ref_mem[a];
            end
        end else begin
            if (fw && starve_m < 15) starve_m++;
            d_granted = 1'b1;
            a = d_addr + 20'd1;
            if (d_we) begin
                ref_mem[d_addr] = d_wdata[7:0];
                ref_mem[a]      = d_wdata[15:8];
                d_is_read = 1'b0;
                d_due     = cyc + 3;
                free_at   = cyc + 4;
                wr_lo     = cyc + 1;
                wr_hi     = cyc + 2;
            end else begin
                d_is_read = 1'b1;
                d_exp     = {ref_mem[a], ref_mem[d_addr]};
                d_due     = cyc + 4;
                free_at   = cyc + 5;
            end
        end
    endtask

    task automatic observe();
        check("f_ack", 64'(f_ack), 64'(cyc == f_due));
        check("d_ack", 64'(d_ack), 64'(cyc == d_due));
        check("mem_wr", 64'(mem_wr), 64'(cyc >= wr_lo && cyc <= wr_hi));
        if (f_ack) dut_seq = {dut_seq, "F"};
        if (d_ack) dut_seq = {dut_seq, "D"};
        if (cyc == f_due) begin
            check("f_data", 64'(f_data), 64'(f_exp));
            f_req = 1'b0; f_granted = 1'b0; f_due = -1;
        end
        if (cyc == d_due) begin
            if (d_is_read) check("d_rdata", 64'(d_rdata), 64'(d_exp));
            d_req = 1'b0; d_granted = 1'b0; d_due = -1;
        end
    endtask

    task automatic tick();
        arbitrate();
        @(negedge clock);
        cyc++;
        observe();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((f_req || d_req || cyc < free_at) && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 64'(n < 60), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_bytes;
        cyc = 0;
        dut_seq = "";
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_byte(AW'(i));
        model_reset();

        repeat (3) @(negedge clock);
        check("rst_f_ack", 64'(f_ack), 64'd0);
        check("rst_d_ack", 64'(d_ack), 64'd0);
        check("rst_mem_wr", 64'(mem_wr), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_out", 64'(mem_out), 64'd0);
        check("rst_f_data", 64'(f_data), 64'd0);
        check("rst_d_rdata", 64'(d_rdata), 64'd0);
        reset_n = 1'b1;
        model_reset();

        issue_fetch(20'h00100);
        wait_done("fetch");
        check("fetch_0x100", 64'(f_data), 64'h060504030201);

        issue_data(1'b1, 20'h00200, 16'hBEEF);
        wait_done("write");
        check("sram_0x200", 64'(sram[20'h00200]), 64'hEF);
        check("sram_0x201", 64'(sram[20'h00201]), 64'hBE);
        issue_data(1'b0, 20'h00200, 16'h0000);
        wait_done("read");
        check("read_0x200", 64'(d_rdata), 64'hBEEF);

        issue_data(1'b0, 20'hFFFFF, 16'h0000);
        wait_done("wrap");
        check("read_wrap", 64'(d_rdata), 64'h1234);

        // Both ports request continuously; grants must cycle D,D,D,D,F.
        dut_seq = "";
        issue_fetch(rand_addr());
        issue_data(1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
        for (int k = 0; k < 300 && dut_seq.len() < 15; k++) begin
            tick();
            if (!f_req) issue_fetch(rand_addr());
            if (!d_req) issue_data(1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
        end
        wait_done("contention");
        for (int i = 0; i < 15; i++) begin
            check($sformatf("grant_order_%0d", i), 64'(dut_seq[i]),
                  64'((i % 5 == 4) ? "F" : "D"));
        end

        // Reset asserted during the 4th READ cycle of a fetch.
        issue_fetch(20'h00100);
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check("arst_f_ack", 64'(f_ack), 64'd0);
        check("arst_d_ack", 64'(d_ack), 64'd0);
        check("arst_mem_wr", 64'(mem_wr), 64'd0);
        check("arst_mem_addr", 64'(mem_addr), 64'd0);
        check("arst_mem_out", 64'(mem_out), 64'd0);
        check("arst_f_data", 64'(f_data), 64'd0);
        check("arst_d_rdata", 64'(d_rdata), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            cyc++;
            check("arst_hold_f_ack", 64'(f_ack), 64'd0);
        end
        reset_n = 1'b1;
        model_reset();
        issue_fetch(20'h00100);
        wait_done("refetch");
        check("refetch_0x100", 64'(f_data), 64'h060504030201);

        for (int k = 0; k < 2500; k++) begin
            if (!f_req && $urandom_range(0, 3) == 0) issue_fetch(rand_addr());
            if (!d_req && $urandom_range(0, 2) == 0)
                issue_data(1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
            tick();
        end
        wait_done("random");

        bad_bytes = 0;
        for (int i = 0; i < 256; i++) begin
            if (sram[AW'(i)] !== ref_mem[AW'(i)]) bad_bytes++;
            if (sram[20'hFFF00 + AW'(i)] !== ref_mem[20'hFFF00 + AW'(i)]) bad_bytes++;
        end
        check("mem_image", 64'(bad_bytes), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
